// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the serial-sequence path (serializer + detector).
//   ser_state_t   : serializer FSM encodings (IDLE / SHIFT / PARITY)
//   DEFAULT_WIDTH : default parallel word width, also used by detector benches
// ---------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        PARITY = 2'b10
    } ser_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : seq_pkg

// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
// Parallel-to-serial stage feeding the serial pattern detector. Words are
// accepted over a valid/ready handshake and sent one bit per clock on x_out.
// Back-to-back words stream without an idle gap; between words x_out rests
// at IDLE_LEVEL.
//
// Optional feature: define SERIALIZER_PARITY_EN to append one even-parity
// bit (XOR of the captured word) after the last data bit of every word.
//
// Parameters:
//   WIDTH      : word width, 2..32
//   MSB_FIRST  : 1 = bit WIDTH-1 first, 0 = bit 0 first
//   IDLE_LEVEL : level on x_out when no data/parity bit is being sent
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   data_in    in   parallel word, sampled on the handshake edge
//   data_valid in   upstream offers a word
//   data_ready out  block can take a word this cycle (combinational)
//   x_out      out  serial bit to the detector
//   bit_valid  out  x_out carries a data or parity bit
//   word_done  out  pulse coincident with the final bit of a word
// ---------------------------------------------------------------------------
module bit_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             x_out,
    output logic             bit_valid,
    output logic             word_done
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    ser_state_t       state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             cur_bit;
    logic             handshake;
    logic [WIDTH-1:0] shreg_shifted;
`ifdef SERIALIZER_PARITY_EN
    logic             parity, parity_nxt;
`endif

    // x_out is taken straight from the shift register flops, so the serial
    // line never carries a combinational path from the inputs.
    assign cur_bit       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
`ifdef SERIALIZER_PARITY_EN
            parity <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state  <= state_nxt;
            shreg  <= shreg_nxt;
            cnt    <= cnt_nxt;
`ifdef SERIALIZER_PARITY_EN
            parity <= parity_nxt;
`endif
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statements can leave one unassigned (no latches).
        state_nxt  = state;
        shreg_nxt  = shreg;
        cnt_nxt    = cnt;
`ifdef SERIALIZER_PARITY_EN
        parity_nxt = parity;
`endif
        x_out      = IDLE_LEVEL;
        bit_valid  = 1'b0;
        word_done  = 1'b0;
        data_ready = 1'b0;

        // Outputs. data_ready is needed before the next-state decision.
        case (state)
            IDLE: begin
                // State is forced to IDLE asynchronously, so gating here is
                // enough to hold data_ready low for the whole reset pulse.
                data_ready = !reset;
            end
            SHIFT: begin
                x_out     = cur_bit;
                bit_valid = 1'b1;
`ifndef SERIALIZER_PARITY_EN
                if (cnt == LAST_BIT) begin
                    word_done  = 1'b1;
                    data_ready = 1'b1;
                end
`endif
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
                x_out      = parity;
                bit_valid  = 1'b1;
                word_done  = 1'b1;
                data_ready = 1'b1;
            end
`endif
            default: ;
        endcase

        handshake = data_valid & data_ready;

        // Next state.
        case (state)
            IDLE: begin
                if (handshake) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cnt != LAST_BIT) begin
                    cnt_nxt   = cnt + CNT_W'(1);
                    shreg_nxt = shreg_shifted;
                end else begin
`ifdef SERIALIZER_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = handshake ? SHIFT : IDLE;
`endif
                end
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
                state_nxt = handshake ? SHIFT : IDLE;
            end
`endif
            default: begin
                // Unused encodings fall back to a clean idle.
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // A new word (from IDLE or on the final-bit cycle) restarts the shifter.
        if (handshake) begin
            shreg_nxt  = data_in;
            cnt_nxt    = '0;
`ifdef SERIALIZER_PARITY_EN
            parity_nxt = ^data_in;
`endif
        end
    end

endmodule : bit_serializer
